// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: effective-address/alignment check at accept, then a
// req/ack data-memory transfer with byte strobes, timeout, and extended load return.
module load_store_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_base,
  input  logic [XLEN-1:0]       req_offset,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_wstrb,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_err,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]            r_funct3;
  logic [OFFW-1:0]       r_off;
  logic [CW-1:0]         r_wait_cnt;
  logic [XLEN-1:0]       r_rsp_data;
  logic [1:0]            r_rsp_err;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [NB-1:0]         r_mem_wstrb;
  logic [XLEN-1:0]       r_mem_wdata;

  logic [XLEN-1:0]       w_ea;
  logic [OFFW-1:0]       w_off;
  logic [1:0]            w_size;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic [NB-1:0]         w_size_mask;
  logic [XLEN-1:0]       w_wdata_masked;
  logic [XLEN-1:0]       w_load_shift;
  logic [XLEN-1:0]       w_load_tmp;
  logic [XLEN-1:0]       w_load_ext;
  logic [7:0]            w_ext_sh;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_timeout_hit;

  assign w_ea      = req_base + req_offset;
  assign w_off     = w_ea[OFFW-1:0];
  assign w_size    = req_funct3[1:0];
  assign w_cnt_inc = r_wait_cnt + CW'(1);
  assign w_timeout_hit = (TIMEOUT > 0) && (w_cnt_inc == CW'(TIMEOUT));

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign mem_req   = (r_state == S_BUS);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;

  // Accept-time decode: funct3 legality, alignment, size mask and lane-masked store data
  always_comb begin
    w_illegal      = 1'b0;
    w_misaligned   = 1'b0;
    w_size_mask    = '0;
    w_wdata_masked = '0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b011:                 w_illegal = (XLEN != 64);
      3'b100, 3'b101:         w_illegal = req_store;
      3'b110:                 w_illegal = req_store || (XLEN != 64);
      default:                w_illegal = 1'b1;
    endcase
    case (w_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = (w_ea[0] != 1'b0);
      2'd2:    w_misaligned = (w_ea[1:0] != 2'b00);
      default: w_misaligned = (w_ea[2:0] != 3'b000);
    endcase
    case (w_size)
      2'd0:    w_size_mask = NB'(8'h01);
      2'd1:    w_size_mask = NB'(8'h03);
      2'd2:    w_size_mask = NB'(8'h0F);
      default: w_size_mask = NB'(8'hFF);
    endcase
    for (int i = 0; i < NB; i++) begin
      if (w_size_mask[i]) begin
        w_wdata_masked[8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        w_wdata_masked[8*i +: 8] = 8'h00;
      end
    end
  end

  // Load return: move addressed bytes to bit 0, then sign/zero-extend via shift pair
  always_comb begin
    w_load_shift = mem_rdata >> {r_off, 3'b000};
    case (r_funct3[1:0])
      2'd0:    w_ext_sh = 8'(XLEN - 8);
      2'd1:    w_ext_sh = 8'(XLEN - 16);
      2'd2:    w_ext_sh = 8'(XLEN - 32);
      default: w_ext_sh = 8'd0;
    endcase
    w_load_tmp = w_load_shift << w_ext_sh;
    if (r_funct3[2]) begin
      w_load_ext = w_load_tmp >> w_ext_sh;
    end else begin
      w_load_ext = XLEN'($signed(w_load_tmp) >>> w_ext_sh);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = (w_illegal || w_misaligned) ? S_RESP : S_BUS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUS: begin
        if (mem_err || mem_ack || w_timeout_hit) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_BUS;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation, bus and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_funct3    <= 3'd0;
      r_off       <= '0;
      r_wait_cnt  <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 2'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3    <= req_funct3;
            r_off       <= w_off;
            r_wait_cnt  <= '0;
            r_rsp_data  <= '0;
            r_mem_we    <= req_store;
            r_mem_addr  <= w_ea[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(NB - 1);
            r_mem_wstrb <= w_size_mask << w_off;
            r_mem_wdata <= req_store ? (w_wdata_masked << {w_off, 3'b000}) : '0;
            if (w_illegal) begin
              r_rsp_err <= 2'd3;
            end else if (w_misaligned) begin
              r_rsp_err <= 2'd1;
            end else begin
              r_rsp_err <= 2'd0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt;
          end
        end
        S_BUS: begin
          r_wait_cnt <= w_cnt_inc;
          // Bus error outranks a simultaneous ack; ack outranks a coincident timeout
          if (mem_err) begin
            r_rsp_err  <= 2'd2;
            r_rsp_data <= '0;
          end else if (mem_ack) begin
            r_rsp_err  <= 2'd0;
            r_rsp_data <= r_mem_we ? '0 : w_load_ext;
          end else if (w_timeout_hit) begin
            r_rsp_err  <= 2'd3;
            r_rsp_data <= '0;
          end else begin
            r_rsp_err  <= r_rsp_err;
          end
        end
        default: begin
          r_wait_cnt <= r_wait_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: table of load/store vectors on XLEN=32 (TIMEOUT=4) and XLEN=64 units,
// plus hand-written timeout, back-pressure and mid-transfer reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_base = 64'd0;
  logic [63:0] req_offset = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_ready = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  logic        a_req_ready, a_rsp_valid, a_mem_req, a_mem_we;
  logic [31:0] a_rsp_data, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_rsp_err;
  logic [3:0]  a_mem_wstrb;
  logic        b_req_ready, b_rsp_valid, b_mem_req, b_mem_we;
  logic [63:0] b_rsp_data, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [1:0]  b_rsp_err;
  logic [7:0]  b_mem_wstrb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel64), .req_ready(a_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base[31:0]), .req_offset(req_offset[31:0]),
    .req_wdata(req_wdata[31:0]),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb),
    .mem_wdata(a_mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata[31:0])
  );

  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(255)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel64), .req_ready(b_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb),
    .mem_wdata(b_mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  // Outputs of whichever unit is currently selected
  wire        m_req_ready = sel64 ? b_req_ready : a_req_ready;
  wire        m_rsp_valid = sel64 ? b_rsp_valid : a_rsp_valid;
  wire [63:0] m_rsp_data  = sel64 ? b_rsp_data  : {32'd0, a_rsp_data};
  wire [1:0]  m_rsp_err   = sel64 ? b_rsp_err   : a_rsp_err;
  wire        m_mem_req   = sel64 ? b_mem_req   : a_mem_req;
  wire        m_mem_we    = sel64 ? b_mem_we    : a_mem_we;
  wire [31:0] m_mem_addr  = sel64 ? b_mem_addr  : a_mem_addr;
  wire [7:0]  m_mem_wstrb = sel64 ? b_mem_wstrb : {4'd0, a_mem_wstrb};
  wire [63:0] m_mem_wdata = sel64 ? b_mem_wdata : {32'd0, a_mem_wdata};

  typedef struct {
    bit          w64;
    bit          store;
    logic [2:0]  f3;
    logic [63:0] base;
    logic [63:0] offset;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;     // 0: no bus transfer expected
    bit          berr;    // assert mem_err together with mem_ack
    logic [31:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [1:0]  e_err;
    logic [63:0] e_data;
  } vec_t;

  function automatic vec_t mk(bit w64, bit st, logic [2:0] f3, logic [63:0] base,
                              logic [63:0] off, logic [63:0] wd, logic [63:0] rd, int lat,
                              bit berr, logic [31:0] ea, logic [7:0] es, logic [63:0] ew,
                              logic [1:0] ee, logic [63:0] ed);
    vec_t v;
    v.w64 = w64; v.store = st; v.f3 = f3; v.base = base; v.offset = off; v.wdata = wd;
    v.rdata = rd; v.lat = lat; v.berr = berr; v.e_addr = ea; v.e_strb = es; v.e_wdata = ew;
    v.e_err = ee; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int idx, input vec_t v, input int hold);
    string p;
    p = $sformatf("v%0d", idx);
    sel64 = v.w64;
    req_store = v.store; req_funct3 = v.f3; req_base = v.base;
    req_offset = v.offset; req_wdata = v.wdata; req_valid = 1'b1;
    #1;
    chk({p, " req_ready"}, {63'd0, m_req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    if (v.lat == 0) begin
      chk({p, " no_mem_req"}, {63'd0, m_mem_req}, 64'd0);
    end else begin
      chk({p, " mem_req"}, {63'd0, m_mem_req}, 64'd1);
      chk({p, " mem_we"}, {63'd0, m_mem_we}, {63'd0, v.store});
      chk({p, " mem_addr"}, {32'd0, m_mem_addr}, {32'd0, v.e_addr});
      chk({p, " mem_wstrb"}, {56'd0, m_mem_wstrb}, {56'd0, v.e_strb});
      chk({p, " mem_wdata"}, m_mem_wdata, v.e_wdata);
      for (int i = 1; i < v.lat; i++) begin
        tick();
        chk({p, " mem_req_held"}, {63'd0, m_mem_req}, 64'd1);
      end
      mem_ack = 1'b1; mem_err = v.berr; mem_rdata = v.rdata;
      tick();
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'hDEAD_BEEF_5A5A_A5A5;
      chk({p, " mem_req_drop"}, {63'd0, m_mem_req}, 64'd0);
    end
    chk({p, " rsp_valid"}, {63'd0, m_rsp_valid}, 64'd1);
    chk({p, " rsp_err"}, {62'd0, m_rsp_err}, {62'd0, v.e_err});
    chk({p, " rsp_data"}, m_rsp_data, v.e_data);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({p, " hold_valid"}, {63'd0, m_rsp_valid}, 64'd1);
      chk({p, " hold_data"}, m_rsp_data, v.e_data);
      chk({p, " hold_ready"}, {63'd0, m_req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({p, " back_idle"}, {62'd0, m_req_ready, m_rsp_valid}, 64'd2);
  endtask

  vec_t vecs[14];

  initial begin
    int first;
    int cnt;
    logic [63:0] rd32;
    rd32 = 64'h0000_0000_8001_1234;
    vecs[0]  = mk(0, 1, 3'b000, 64'h100, 64'd3, 64'hAABBCCDD, 64'd0, 2, 0,
                  32'h100, 8'h08, 64'hDD00_0000, 2'd0, 64'd0);
    vecs[1]  = mk(0, 0, 3'b001, 64'h200, 64'd2, 64'd0, rd32, 1, 0,
                  32'h200, 8'h0C, 64'd0, 2'd0, 64'h0000_0000_FFFF_8001);
    vecs[2]  = mk(0, 0, 3'b101, 64'h200, 64'd2, 64'd0, rd32, 1, 0,
                  32'h200, 8'h0C, 64'd0, 2'd0, 64'h0000_0000_0000_8001);
    vecs[3]  = mk(0, 0, 3'b000, 64'h200, 64'd1, 64'd0, rd32, 1, 0,
                  32'h200, 8'h02, 64'd0, 2'd0, 64'h0000_0000_0000_0012);
    vecs[4]  = mk(0, 0, 3'b000, 64'h200, 64'd3, 64'd0, rd32, 3, 0,
                  32'h200, 8'h08, 64'd0, 2'd0, 64'h0000_0000_FFFF_FF80);
    vecs[5]  = mk(0, 0, 3'b100, 64'h200, 64'd3, 64'd0, rd32, 1, 0,
                  32'h200, 8'h08, 64'd0, 2'd0, 64'h0000_0000_0000_0080);
    vecs[6]  = mk(0, 0, 3'b010, 64'h200, 64'd6, 64'd0, rd32, 0, 0,
                  32'h0, 8'h0, 64'd0, 2'd1, 64'd0);
    vecs[7]  = mk(0, 1, 3'b001, 64'h0, 64'd3, 64'h1234, 64'd0, 0, 0,
                  32'h0, 8'h0, 64'd0, 2'd1, 64'd0);
    vecs[8]  = mk(0, 0, 3'b011, 64'h8, 64'd0, 64'd0, 64'd0, 0, 0,
                  32'h0, 8'h0, 64'd0, 2'd3, 64'd0);
    vecs[9]  = mk(0, 1, 3'b100, 64'h8, 64'd0, 64'h55, 64'd0, 0, 0,
                  32'h0, 8'h0, 64'd0, 2'd3, 64'd0);
    vecs[10] = mk(0, 0, 3'b010, 64'h300, 64'd0, 64'd0, rd32, 2, 1,
                  32'h300, 8'h0F, 64'd0, 2'd2, 64'd0);
    vecs[11] = mk(0, 1, 3'b010, 64'h10, 64'hFFFF_FFFF_FFFF_FFFC, 64'h12345678, 64'd0, 3, 0,
                  32'hC, 8'h0F, 64'h1234_5678, 2'd0, 64'd0);
    vecs[12] = mk(1, 0, 3'b011, 64'h8, 64'd0, 64'd0, 64'h8000_0000_0000_0001, 1, 0,
                  32'h8, 8'hFF, 64'd0, 2'd0, 64'h8000_0000_0000_0001);
    vecs[13] = mk(1, 0, 3'b110, 64'h8, 64'd4, 64'd0, 64'h8000_0000_0000_0001, 1, 0,
                  32'h8, 8'hF0, 64'd0, 2'd0, 64'h0000_0000_8000_0000);

    // Reset values on both units
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      chk($sformatf("rst%0d ready_valid_req", s),
          {61'd0, m_req_ready, m_rsp_valid, m_mem_req}, 64'd4);
      chk($sformatf("rst%0d rsp", s), m_rsp_data | {62'd0, m_rsp_err}, 64'd0);
      chk($sformatf("rst%0d bus", s),
          {31'd0, m_mem_we, m_mem_addr} | {56'd0, m_mem_wstrb} | m_mem_wdata, 64'd0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      run(i, vecs[i], 0);
    end

    // XLEN=64 sign-extended lw, sd and upper-lane sw
    run(20, mk(1, 0, 3'b010, 64'h8, 64'd4, 64'd0, 64'h8000_0000_0000_0001, 2, 0,
               32'h8, 8'hF0, 64'd0, 2'd0, 64'hFFFF_FFFF_8000_0000), 0);
    run(21, mk(1, 1, 3'b011, 64'h10, 64'd0, 64'h1122_3344_5566_7788, 64'd0, 1, 0,
               32'h10, 8'hFF, 64'h1122_3344_5566_7788, 2'd0, 64'd0), 0);
    run(22, mk(1, 1, 3'b010, 64'h10, 64'd4, 64'hAABB_CCDD, 64'd0, 1, 0,
               32'h10, 8'hF0, 64'hAABB_CCDD_0000_0000, 2'd0, 64'd0), 0);

    // Back-pressure: response held 5 cycles with rsp_ready low
    run(30, mk(0, 0, 3'b001, 64'h200, 64'd2, 64'd0, rd32, 1, 0,
               32'h200, 8'h0C, 64'd0, 2'd0, 64'h0000_0000_FFFF_8001), 5);

    // Timeout on the TIMEOUT=4 unit: mem_req for 4 cycles then err=3
    sel64 = 1'b0; req_store = 1'b0; req_funct3 = 3'b010;
    req_base = 64'h400; req_offset = 64'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    first = -1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (m_rsp_valid) begin
        first = j;
        break;
      end
      if (m_mem_req) cnt++;
      tick();
    end
    chk("timeout mem_req_cycles", 64'(cnt), 64'd4);
    chk("timeout rsp_at", 64'(first), 64'd4);
    chk("timeout rsp_err", {62'd0, m_rsp_err}, 64'd3);
    chk("timeout rsp_data", m_rsp_data, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("timeout back_idle", {63'd0, m_req_ready}, 64'd1);

    // Reset in the middle of a bus transfer
    req_funct3 = 3'b010; req_base = 64'h500; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("midrst busy", {63'd0, m_mem_req}, 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst state", {61'd0, m_mem_req, m_req_ready, m_rsp_valid}, 64'd2);
    rst_n = 1'b1;
    tick();
    chk("midrst after", {61'd0, m_mem_req, m_req_ready, m_rsp_valid}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
